decoder_xpt_sequencer: RTL and testbench
========================================

Name: decoder_xpt_sequencer

Overview:
- Clocked successor to the combinational opcode/phase decoder.
- Owns the instruction register (ITABLE) and the execution-phase counter (XPT), and runs the M1, operand-read, memory-read/write and execute cycles itself.
- Issues a one-cycle register-write strobe per instruction.
- Sits between the memory bus handshake and the register file.
- Opcode width, phase width and bus wait timeout are parameters.

Parameters:
- OP_WIDTH, 8, opcode/data width; at least 8.
- XPT_WIDTH, 4, phase counter width; at least 3.
- WAIT_LIMIT, 15, consecutive not-ready cycles before a memory cycle aborts; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  run permission.
- mem_ready  in  1  current memory cycle completes at this edge.
- mem_data  in  OP_WIDTH  read data.
- mem_req  out  1  memory cycle active.
- mem_we  out  1  the active cycle is a write.
- cm  out  2  cycle mode: 00 none, 01 M1, 10 read, 11 write.
- addr_sel  out  2  address source: 0 PC, 1 {op_hi,op_lo}, 2 HL.
- pc_inc  out  1  pulse: a PC-addressed read completed.
- itable  out  OP_WIDTH  latched opcode.
- xpt  out  XPT_WIDTH  current phase.
- op_lo  out  OP_WIDTH  operand byte 0.
- op_hi  out  OP_WIDTH  operand byte 1.
- data_reg  out  OP_WIDTH  indirect read data.
- write_a, write_l, write_h, write_pc_low, write_pc_high, invert_in  out  1 each  execute strobes.
- op_done  out  1  pulse: instruction finished.
- illegal  out  1  pulse: unsupported opcode.
- bus_error  out  1  pulse: wait timeout.

Behaviour:
- Reset: state IDLE. All registers and outputs are 0. Reset mid-cycle aborts immediately; there are no partial strobes.
- States: IDLE, M1, RD, WR, EXEC.
- mem_req=1 in M1, RD and WR; mem_we=1 only in WR. cm and addr_sel are decoded from the state.
- IDLE: moves to M1 at the first edge with enable=1.
- M1 (cm=01, addr_sel=0): on mem_ready, itable<=mem_data, pc_inc pulses, xpt<=1.
- Each completed RD or WR increments xpt; EXEC holds xpt.
- Leaving EXEC: xpt<=0 and the next state is M1, or IDLE if enable=0 in EXEC. enable is ignored in every other state.
- Sequences after M1, selected by itable when bits [OP_WIDTH-1:3] are all 0:
  - 00: EXEC.
  - 01: RD(PC→op_lo), then EXEC with write_a.
  - 02: RD(PC→op_lo), RD(PC→op_hi), then EXEC with write_l and write_h together.
  - 03: RD lo, RD hi, WR(addr_sel=1), then EXEC.
  - 04: RD lo, RD hi, RD(addr_sel=1→data_reg, no pc_inc), then EXEC with write_a.
  - 05: EXEC with write_a and invert_in.
  - 06: RD lo, RD hi, then EXEC with write_pc_low and write_pc_high.
  - 07: WR(addr_sel=2), then EXEC.
  - Any other opcode: EXEC with illegal=1 and no strobes.
- Strobes, op_done and illegal are asserted only during the single EXEC cycle and are registered, glitch-free.
- Maximum xpt is 4 (opcodes 03 and 04). xpt never wraps.
- Wait counter:
  - Counts consecutive mem_req=1 cycles with mem_ready=0; clears on completion or when leaving the state.
  - When the count equals WAIT_LIMIT (WAIT_LIMIT≠0), bus_error pulses for 1 cycle and the state jumps to M1 with xpt=0.
  - On abort: no EXEC, no strobes, no op_done, and latched operands are kept.
  - If mem_ready=1 in the same cycle the limit is hit, completion wins and there is no bus_error.
- Latency with zero wait states:
  - NOP: 2 cycles, M1 to op_done.
  - 04: 5 cycles.

Test Plan:
- Reset, enable=1, ready always 1, data 00 → M1 one cycle after reset release; op_done at cycle 2; xpt sequence 0,1,0; pc_inc once per instruction.
- Opcode 02, bytes 34,12 → op_lo=34, op_hi=12; write_l and write_h high together for exactly 1 cycle at xpt=3; pc_inc pulses 3 times.
- Opcode 04, bytes 00,80, indirect read AB, 2 wait states on each cycle → third read has addr_sel=1; data_reg=AB; write_a at xpt=4; total 13 cycles.
- Opcode 03, WAIT_LIMIT=3, mem_ready held low in WR → bus_error on the 3rd wait cycle; next state M1 with xpt=0; no op_done.
- Opcode 0x5A → illegal and op_done pulse 1 cycle; no strobes. Next, opcode 05 → write_a and invert_in together.
- Assert reset in the middle of opcode 06 at xpt=2 → all outputs 0 immediately; no write_pc strobes; restart from IDLE.

Source files
------------

// File: rtl/decoder_xpt_sequencer.sv
// Clocked opcode/phase sequencer: owns the instruction register and phase counter,
// drives memory cycles (M1, operand read, indirect read/write) and issues execute strobes.
module decoder_xpt_sequencer #(
    parameter int OP_WIDTH   = 8,
    parameter int XPT_WIDTH  = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 mem_ready,
    input  logic [OP_WIDTH-1:0]  mem_data,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [1:0]           cm,
    output logic [1:0]           addr_sel,
    output logic                 pc_inc,
    output logic [OP_WIDTH-1:0]  itable,
    output logic [XPT_WIDTH-1:0] xpt,
    output logic [OP_WIDTH-1:0]  op_lo,
    output logic [OP_WIDTH-1:0]  op_hi,
    output logic [OP_WIDTH-1:0]  data_reg,
    output logic                 write_a,
    output logic                 write_l,
    output logic                 write_h,
    output logic                 write_pc_low,
    output logic                 write_pc_high,
    output logic                 invert_in,
    output logic                 op_done,
    output logic                 illegal,
    output logic                 bus_error
);

    localparam int WCW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_M1, S_RD, S_WR, S_EXEC} state_t;

    state_t                state, state_nxt, seq_next;
    logic [OP_WIDTH-1:0]   itable_nxt, op_lo_nxt, op_hi_nxt, data_reg_nxt, cur_op;
    logic [XPT_WIDTH-1:0]  xpt_nxt, xpt_inc;
    logic [WCW-1:0]        wait_cnt, wait_nxt;
    logic [5:0]            strobe_q, strobe_nxt;
    logic                  done_nxt, illegal_nxt;
    logic                  indirect_rd, timeout;

    function automatic logic is_legal(input logic [OP_WIDTH-1:0] op);
        return op[OP_WIDTH-1:3] == '0;
    endfunction

    // Phase to run after n memory cycles (M1 included) have completed for opcode op.
    function automatic state_t next_phase(input logic [OP_WIDTH-1:0] op,
                                          input logic [XPT_WIDTH-1:0] n);
        state_t s;
        s = S_EXEC;
        if (is_legal(op)) begin
            case (op[2:0])
                3'd1:       if (n == XPT_WIDTH'(1)) s = S_RD;
                3'd2, 3'd6: if (n <= XPT_WIDTH'(2)) s = S_RD;
                3'd3: begin
                    if (n <= XPT_WIDTH'(2))      s = S_RD;
                    else if (n == XPT_WIDTH'(3)) s = S_WR;
                end
                3'd4:       if (n <= XPT_WIDTH'(3)) s = S_RD;
                3'd7:       if (n == XPT_WIDTH'(1)) s = S_WR;
                default:    ;
            endcase
        end
        return s;
    endfunction

    // Strobe order: {write_a, write_l, write_h, write_pc_low, write_pc_high, invert_in}
    function automatic logic [5:0] exec_strobes(input logic [OP_WIDTH-1:0] op);
        logic [5:0] s;
        s = '0;
        if (is_legal(op)) begin
            case (op[2:0])
                3'd1, 3'd4: s = 6'b100000;
                3'd2:       s = 6'b011000;
                3'd5:       s = 6'b100001;
                3'd6:       s = 6'b000110;
                default:    s = '0;
            endcase
        end
        return s;
    endfunction

    assign mem_req     = (state == S_M1) || (state == S_RD) || (state == S_WR);
    assign mem_we      = (state == S_WR);
    assign indirect_rd = (state == S_RD) && (itable == OP_WIDTH'(4)) && (xpt == XPT_WIDTH'(3));
    assign timeout     = (WAIT_LIMIT != 0) && mem_req && !mem_ready
                         && (wait_cnt == WCW'(WAIT_LIMIT - 1));
    assign pc_inc      = mem_req && mem_ready && ((state == S_M1) || ((state == S_RD) && !indirect_rd));
    assign bus_error   = timeout;
    assign cur_op      = (state == S_M1) ? mem_data : itable;
    assign xpt_inc     = xpt + XPT_WIDTH'(1);
    assign seq_next    = next_phase(cur_op, xpt_inc);

    assign {write_a, write_l, write_h, write_pc_low, write_pc_high, invert_in} = strobe_q;

    always_comb begin
        cm       = 2'b00;
        addr_sel = 2'd0;
        case (state)
            S_M1: cm = 2'b01;
            S_RD: begin
                cm       = 2'b10;
                addr_sel = indirect_rd ? 2'd1 : 2'd0;
            end
            S_WR: begin
                cm       = 2'b11;
                addr_sel = (itable == OP_WIDTH'(7)) ? 2'd2 : 2'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        itable_nxt   = itable;
        xpt_nxt      = xpt;
        op_lo_nxt    = op_lo;
        op_hi_nxt    = op_hi;
        data_reg_nxt = data_reg;
        wait_nxt     = wait_cnt;
        strobe_nxt   = '0;
        done_nxt     = 1'b0;
        illegal_nxt  = 1'b0;
        case (state)
            S_IDLE: if (enable) state_nxt = S_M1;
            S_M1, S_RD, S_WR: begin
                if (mem_ready) begin
                    wait_nxt  = '0;
                    xpt_nxt   = xpt_inc;
                    state_nxt = seq_next;
                    if (state == S_M1)                                itable_nxt   = mem_data;
                    else if (indirect_rd)                             data_reg_nxt = mem_data;
                    else if (state == S_RD && xpt == XPT_WIDTH'(1))   op_lo_nxt    = mem_data;
                    else if (state == S_RD)                           op_hi_nxt    = mem_data;
                    // Execute outputs are registered on entry so they cover exactly the EXEC cycle.
                    if (seq_next == S_EXEC) begin
                        strobe_nxt  = exec_strobes(cur_op);
                        done_nxt    = 1'b1;
                        illegal_nxt = !is_legal(cur_op);
                    end
                end else if (timeout) begin
                    wait_nxt  = '0;
                    xpt_nxt   = '0;
                    state_nxt = S_M1;
                end else if (WAIT_LIMIT != 0) begin
                    wait_nxt = wait_cnt + WCW'(1);
                end
            end
            S_EXEC: begin
                xpt_nxt   = '0;
                state_nxt = enable ? S_M1 : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            itable   <= '0;
            xpt      <= '0;
            op_lo    <= '0;
            op_hi    <= '0;
            data_reg <= '0;
            wait_cnt <= '0;
            strobe_q <= '0;
            op_done  <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state    <= state_nxt;
            itable   <= itable_nxt;
            xpt      <= xpt_nxt;
            op_lo    <= op_lo_nxt;
            op_hi    <= op_hi_nxt;
            data_reg <= data_reg_nxt;
            wait_cnt <= wait_nxt;
            strobe_q <= strobe_nxt;
            op_done  <= done_nxt;
            illegal  <= illegal_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_xpt_sequencer.sv
// Bench for decoder_xpt_sequencer: hand-computed vector table, directed corner sequences,
// and random instructions checked against an instruction-level reference model.
module tb_decoder_xpt_sequencer;

    logic       clk = 1'b0;
    logic       reset, enable, mem_ready;
    logic [7:0] mem_data;
    logic       mem_req, mem_we, pc_inc;
    logic [1:0] cm, addr_sel;
    logic [7:0] itable, op_lo, op_hi, data_reg;
    logic [3:0] xpt;
    logic       write_a, write_l, write_h, write_pc_low, write_pc_high, invert_in;
    logic       op_done, illegal, bus_error;

    decoder_xpt_sequencer #(
        .OP_WIDTH  (8),
        .XPT_WIDTH (4),
        .WAIT_LIMIT(3)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mem_ready(mem_ready), .mem_data(mem_data),
        .mem_req(mem_req), .mem_we(mem_we), .cm(cm), .addr_sel(addr_sel), .pc_inc(pc_inc),
        .itable(itable), .xpt(xpt), .op_lo(op_lo), .op_hi(op_hi), .data_reg(data_reg),
        .write_a(write_a), .write_l(write_l), .write_h(write_h), .write_pc_low(write_pc_low),
        .write_pc_high(write_pc_high), .invert_in(invert_in), .op_done(op_done),
        .illegal(illegal), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    logic [5:0]  strobes;
    logic [51:0] all_out;
    assign strobes = {write_a, write_l, write_h, write_pc_low, write_pc_high, invert_in};
    assign all_out = {mem_req, mem_we, cm, addr_sel, pc_inc, itable, xpt, op_lo, op_hi,
                      data_reg, strobes, op_done, illegal, bus_error};

    typedef struct packed {
        logic       done;
        logic [7:0] itab;
        logic [3:0] xpt0;
        logic [7:0] lo, hi, data;
        logic [5:0] strb;
        logic       ill;
        logic [3:0] xpt;
        logic [7:0] cyc;
        logic [3:0] pcinc;
        logic [15:0] seq;
        logic [3:0] berr;
    } res_t;

    typedef struct packed {
        logic [7:0] op, b0, b1, ind;
        logic [1:0] waits;
        res_t       exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Reference model state and per-opcode tables (index = opcode 0..7)
    logic [7:0] m_lo, m_hi, m_data;
    int         npc_t  [8] = '{0, 1, 2, 2, 2, 0, 2, 0};
    logic [5:0] strb_t [8] = '{6'b000000, 6'b100000, 6'b011000, 6'b000000,
                               6'b100000, 6'b100001, 6'b000110, 6'b000000};

    logic saw_done, saw_strb, s_berr, s_we;
    logic [3:0] s_xpt;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic res_t mkres(input logic [7:0] op, lo, hi, d, input logic [5:0] s,
                                   input logic il, input logic [3:0] x, input logic [7:0] cy,
                                   input logic [3:0] pc, input logic [15:0] sq);
        res_t r;
        r = '0;
        r.done = 1'b1; r.itab = op; r.lo = lo; r.hi = hi; r.data = d; r.strb = s;
        r.ill = il; r.xpt = x; r.cyc = cy; r.pcinc = pc; r.seq = sq;
        return r;
    endfunction

    function automatic vec_t mkv(input logic [7:0] op, b0, b1, ind, input logic [1:0] w,
                                 input logic [7:0] lo, hi, d, input logic [5:0] s,
                                 input logic il, input logic [3:0] x, input logic [7:0] cy,
                                 input logic [3:0] pc, input logic [15:0] sq);
        vec_t v;
        v.op = op; v.b0 = b0; v.b1 = b1; v.ind = ind; v.waits = w;
        v.exp = mkres(op, lo, hi, d, s, il, x, cy, pc, sq);
        return v;
    endfunction

    // Instruction-level model: memory cycles from opcode class, latency from wait count.
    function automatic res_t model(input logic [7:0] op, b0, b1, ind, input int waits);
        res_t e;
        logic legal, rd_ind, wr;
        int   npc, ncyc;
        logic [15:0] sq;
        legal  = (op < 8);
        npc    = legal ? npc_t[op[2:0]] : 0;
        rd_ind = legal && (op == 8'd4);
        wr     = legal && (op == 8'd3 || op == 8'd7);
        if (npc >= 1) m_lo = b0;
        if (npc >= 2) m_hi = b1;
        if (rd_ind) m_data = ind;
        ncyc = npc + int'(rd_ind) + int'(wr);
        sq = 16'h0004;
        for (int i = 0; i < npc; i++) sq = {sq[11:0], 4'h8};
        if (rd_ind) sq = {sq[11:0], 4'h9};
        if (wr)     sq = {sq[11:0], (op == 8'd7) ? 4'hE : 4'hD};
        e = mkres(op, m_lo, m_hi, m_data, legal ? strb_t[op[2:0]] : 6'b0, !legal,
                  4'(1 + ncyc), 8'((ncyc + 1) * (waits + 1) + 1), 4'(1 + npc), sq);
        return e;
    endfunction

    // Acts as the memory for one instruction; called at posedge+1 in IDLE or M1.
    task automatic run_instr(input logic [7:0] op, b0, b1, ind, input int waits, output res_t r);
        logic [7:0] stream [3];
        int   idx, wleft;
        logic started;
        stream[0] = op; stream[1] = b0; stream[2] = b1;
        idx = 0; wleft = waits; started = 1'b0;
        r = '0;
        enable = 1'b1;
        for (int c = 0; c < 200 && !r.done; c++) begin
            mem_ready = 1'b0;
            mem_data  = 8'h00;
            if (mem_req) begin
                if (wleft > 0) begin
                    wleft--;
                end else begin
                    mem_ready = 1'b1;
                    wleft     = waits;
                    r.seq     = {r.seq[11:0], cm, addr_sel};
                    if (!mem_we) begin
                        if (addr_sel == 2'd1) mem_data = ind;
                        else if (idx < 3) begin
                            mem_data = stream[idx];
                            idx++;
                        end
                    end
                end
            end
            @(negedge clk);
            if (cm == 2'b01 && !started) begin
                started = 1'b1;
                r.xpt0  = xpt;
            end
            if (started)   r.cyc   = r.cyc + 8'd1;
            if (pc_inc)    r.pcinc = r.pcinc + 4'd1;
            if (bus_error) r.berr  = r.berr + 4'd1;
            chk("strobe_outside_exec", {58'd0, strobes & {6{~op_done}}}, 64'd0);
            if (op_done) begin
                r.done = 1'b1; r.itab = itable; r.lo = op_lo; r.hi = op_hi; r.data = data_reg;
                r.strb = strobes; r.ill = illegal; r.xpt = xpt;
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic cmp_res(input string tag, input res_t g, input res_t e);
        chk({tag, ".done"},   64'(g.done),  64'(e.done));
        chk({tag, ".itable"}, 64'(g.itab),  64'(e.itab));
        chk({tag, ".xpt_m1"}, 64'(g.xpt0),  64'(e.xpt0));
        chk({tag, ".op_lo"},  64'(g.lo),    64'(e.lo));
        chk({tag, ".op_hi"},  64'(g.hi),    64'(e.hi));
        chk({tag, ".data"},   64'(g.data),  64'(e.data));
        chk({tag, ".strobe"}, 64'(g.strb),  64'(e.strb));
        chk({tag, ".illegal"},64'(g.ill),   64'(e.ill));
        chk({tag, ".xpt"},    64'(g.xpt),   64'(e.xpt));
        chk({tag, ".cycles"}, 64'(g.cyc),   64'(e.cyc));
        chk({tag, ".pc_inc"}, 64'(g.pcinc), 64'(e.pcinc));
        chk({tag, ".cycseq"}, 64'(g.seq),   64'(e.seq));
        chk({tag, ".buserr"}, 64'(g.berr),  64'(e.berr));
    endtask

    // One hand-driven cycle: inputs applied at posedge+1, outputs sampled at negedge.
    task automatic serve(input logic rdy, input logic [7:0] d);
        mem_ready = rdy;
        mem_data  = d;
        @(negedge clk);
        saw_done = saw_done | op_done;
        saw_strb = saw_strb | (|strobes);
        s_berr   = bus_error;
        s_we     = mem_we;
        s_xpt    = xpt;
        @(posedge clk); #1;
    endtask

    vec_t vt [11];
    res_t got, e;

    initial begin
        reset = 1'b1; enable = 1'b0; mem_ready = 1'b0; mem_data = 8'h00;
        vt[0]  = mkv(8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 6'b000000, 1'b0, 4'd1, 8'd2,  4'd1, 16'h0004);
        vt[1]  = mkv(8'h02, 8'h34, 8'h12, 8'h00, 2'd0, 8'h34, 8'h12, 8'h00, 6'b011000, 1'b0, 4'd3, 8'd4,  4'd3, 16'h0488);
        vt[2]  = mkv(8'h04, 8'h00, 8'h80, 8'hAB, 2'd2, 8'h00, 8'h80, 8'hAB, 6'b100000, 1'b0, 4'd4, 8'd13, 4'd3, 16'h4889);
        vt[3]  = mkv(8'h5A, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 8'h80, 8'hAB, 6'b000000, 1'b1, 4'd1, 8'd2,  4'd1, 16'h0004);
        vt[4]  = mkv(8'h05, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 8'h80, 8'hAB, 6'b100001, 1'b0, 4'd1, 8'd2,  4'd1, 16'h0004);
        vt[5]  = mkv(8'h01, 8'h77, 8'h00, 8'h00, 2'd1, 8'h77, 8'h80, 8'hAB, 6'b100000, 1'b0, 4'd2, 8'd5,  4'd2, 16'h0048);
        vt[6]  = mkv(8'h06, 8'h11, 8'h22, 8'h00, 2'd0, 8'h11, 8'h22, 8'hAB, 6'b000110, 1'b0, 4'd3, 8'd4,  4'd3, 16'h0488);
        vt[7]  = mkv(8'h07, 8'h00, 8'h00, 8'h00, 2'd1, 8'h11, 8'h22, 8'hAB, 6'b000000, 1'b0, 4'd2, 8'd5,  4'd1, 16'h004E);
        vt[8]  = mkv(8'h03, 8'h56, 8'h78, 8'h00, 2'd0, 8'h56, 8'h78, 8'hAB, 6'b000000, 1'b0, 4'd4, 8'd5,  4'd3, 16'h488D);
        vt[9]  = mkv(8'h08, 8'h00, 8'h00, 8'h00, 2'd0, 8'h56, 8'h78, 8'hAB, 6'b000000, 1'b1, 4'd1, 8'd2,  4'd1, 16'h0004);
        vt[10] = mkv(8'hFF, 8'h00, 8'h00, 8'h00, 2'd0, 8'h56, 8'h78, 8'hAB, 6'b000000, 1'b1, 4'd1, 8'd2,  4'd1, 16'h0004);

        // Reset state, then IDLE holds while enable is low
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(all_out), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_cm_0", 64'(cm), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_cm_1", 64'(cm), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_instr(vt[i].op, vt[i].b0, vt[i].b1, vt[i].ind, int'(vt[i].waits), got);
            cmp_res($sformatf("vec%0d", i), got, vt[i].exp);
        end

        // Wait timeout in the write cycle of opcode 03
        saw_done = 1'b0; saw_strb = 1'b0;
        serve(1'b1, 8'h03);
        serve(1'b1, 8'h9A);
        serve(1'b1, 8'hBC);
        serve(1'b0, 8'h00);
        chk("to_in_wr", 64'(s_we), 64'd1);
        chk("to_xpt_wr", 64'(s_xpt), 64'd3);
        chk("to_berr_w1", 64'(s_berr), 64'd0);
        serve(1'b0, 8'h00);
        chk("to_berr_w2", 64'(s_berr), 64'd0);
        serve(1'b0, 8'h00);
        chk("to_berr_w3", 64'(s_berr), 64'd1);
        chk("to_next_cm", 64'(cm), 64'd1);
        chk("to_next_xpt", 64'(xpt), 64'd0);
        chk("to_no_done", 64'({saw_done, saw_strb}), 64'd0);
        chk("to_kept_ops", 64'({op_lo, op_hi}), 64'h9ABC);
        run_instr(8'h00, 8'h00, 8'h00, 8'h00, 0, got);
        cmp_res("after_to", got, mkres(8'h00, 8'h9A, 8'hBC, 8'hAB, 6'b0, 1'b0, 4'd1, 8'd2, 4'd1, 16'h0004));

        // Reset in the middle of opcode 06 at xpt=2
        saw_done = 1'b0; saw_strb = 1'b0;
        serve(1'b1, 8'h06);
        serve(1'b1, 8'h11);
        chk("mid_xpt", 64'(xpt), 64'd2);
        chk("mid_cm", 64'(cm), 64'd2);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_reset_outputs", 64'(all_out), 64'd0);
        chk("mid_no_strobes", 64'({saw_done, saw_strb}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(8'h00, 8'h00, 8'h00, 8'h00, 0, got);
        cmp_res("after_reset", got, mkres(8'h00, 8'h00, 8'h00, 8'h00, 6'b0, 1'b0, 4'd1, 8'd2, 4'd1, 16'h0004));

        // Random instructions against the model
        m_lo = 8'h00; m_hi = 8'h00; m_data = 8'h00;
        for (int n = 0; n < 120; n++) begin
            logic [7:0] op, b0, b1, ind;
            int w;
            op  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
            b0  = 8'($urandom);
            b1  = 8'($urandom);
            ind = 8'($urandom);
            w   = int'($urandom_range(0, 2));
            e   = model(op, b0, b1, ind, w);
            run_instr(op, b0, b1, ind, w, got);
            cmp_res($sformatf("rnd%0d_op%02h", n, op), got, e);
        end

        // enable low during EXEC returns to IDLE
        enable = 1'b0;
        saw_done = 1'b0;
        serve(1'b1, 8'h00);
        serve(1'b0, 8'h00);
        chk("en_off_done", 64'(saw_done), 64'd1);
        chk("en_off_idle", 64'({mem_req, cm}), 64'd0);
        serve(1'b0, 8'h00);
        chk("en_off_stay", 64'({mem_req, cm}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
